// File: rtl/inert_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : inert_rd_sched
// Purpose  : Read scheduler for the inertial sensor feeding the balance
//            controller. After reset it issues two configuration writes,
//            then on every period tick (while en=1) reads pitch lo/hi and
//            pitch-rate lo/hi through the shared sensor command engine.
//            It publishes ptch/ptch_rt together with a one-cycle vld pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   en         in   1   enables periodic sampling
//   cmd_req    out  1   request to the command engine
//   cmd_wr     out  1   1 = write, 0 = read
//   cmd_addr   out  7   sensor register address
//   cmd_wdata  out  8   write data
//   cmd_ack    in   1   one-cycle completion pulse from the engine
//   cmd_rdata  in   8   read data, valid with cmd_ack
//   ptch       out  16  pitch {hi,lo}
//   ptch_rt    out  16  pitch rate {hi,lo}
//   vld        out  1   one-cycle pulse with each new ptch/ptch_rt pair
//   init_done  out  1   configuration writes completed
//   err        out  1   sticky command timeout flag
// ----------------------------------------------------------------------------
// Build option
//   INERT_TIMEOUT_EN : when defined, a watchdog abandons a command that is
//                      not acknowledged within TMO_CYC cycles and sets err.
//                      When undefined, commands wait forever and err = 0.
// ============================================================================
module inert_rd_sched #(
    parameter int fast_sim = 1
`ifdef INERT_TIMEOUT_EN
   ,parameter int TMO_CYC  = 255
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        cmd_req,
    output logic        cmd_wr,
    output logic [6:0]  cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic        cmd_ack,
    input  logic [7:0]  cmd_rdata,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        vld,
    output logic        init_done,
    output logic        err
);

    // Period timer width: 512-clock period in fast simulation, 65536 otherwise.
    localparam int TW = (fast_sim != 0) ? 9 : 16;

    typedef enum logic [2:0] {
        INIT0 = 3'd0,
        INIT1 = 3'd1,
        WAIT  = 3'd2,
        RD_PL = 3'd3,
        RD_PH = 3'd4,
        RD_RL = 3'd5,
        RD_RH = 3'd6,
        PUB   = 3'd7
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic          tick;
    logic          done;
    logic          tmo;
    logic          cmd_state;
    logic          raise;
    logic          wr_nxt;
    logic [6:0]    addr_nxt;
    logic [7:0]    wdata_nxt;
    logic [7:0]    lo_p;
    logic [7:0]    hi_p;
    logic [7:0]    lo_r;

    // Tick is the last count before the free-running timer wraps.
    assign tick  = &timer;
    // An ack only counts while a request is actually outstanding.
    assign done  = cmd_req & cmd_ack;
    // Requests are raised one cycle after entering a command state, which
    // also guarantees an idle cycle between back-to-back commands.
    assign raise = cmd_state & ~cmd_req;

`ifdef INERT_TIMEOUT_EN
    localparam int WDW = $clog2(TMO_CYC + 1);

    logic [WDW-1:0] wdog;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if (cmd_req && !cmd_ack) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    // Fires in the request's TMO_CYC-th unacknowledged cycle so cmd_req is
    // high for exactly TMO_CYC cycles.
    assign tmo = cmd_req & ~cmd_ack & (wdog == WDW'(TMO_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (tmo) begin
            err <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_state = 1'b1;
        wr_nxt    = 1'b0;
        addr_nxt  = 7'h00;
        wdata_nxt = 8'h00;
        case (state)
            INIT0: begin
                wr_nxt    = 1'b1;
                addr_nxt  = 7'h10;
                wdata_nxt = 8'h62;
                if (done) begin
                    state_nxt = INIT1;
                end else if (tmo) begin
                    state_nxt = INIT0;
                end
            end
            INIT1: begin
                wr_nxt    = 1'b1;
                addr_nxt  = 7'h11;
                wdata_nxt = 8'h4C;
                if (done) begin
                    state_nxt = WAIT;
                end else if (tmo) begin
                    state_nxt = INIT0;
                end
            end
            WAIT: begin
                cmd_state = 1'b0;
                if (tick && en) begin
                    state_nxt = RD_PL;
                end
            end
            RD_PL: begin
                addr_nxt = 7'h22;
                if (done) begin
                    state_nxt = RD_PH;
                end else if (tmo) begin
                    state_nxt = WAIT;
                end
            end
            RD_PH: begin
                addr_nxt = 7'h23;
                if (done) begin
                    state_nxt = RD_RL;
                end else if (tmo) begin
                    state_nxt = WAIT;
                end
            end
            RD_RL: begin
                addr_nxt = 7'h24;
                if (done) begin
                    state_nxt = RD_RH;
                end else if (tmo) begin
                    state_nxt = WAIT;
                end
            end
            RD_RH: begin
                addr_nxt = 7'h25;
                if (done) begin
                    state_nxt = PUB;
                end else if (tmo) begin
                    state_nxt = WAIT;
                end
            end
            PUB: begin
                cmd_state = 1'b0;
                state_nxt = WAIT;
            end
            default: begin
                cmd_state = 1'b0;
                state_nxt = INIT0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer     <= '0;
            cmd_req   <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= 7'h00;
            cmd_wdata <= 8'h00;
            lo_p      <= 8'h00;
            hi_p      <= 8'h00;
            lo_r      <= 8'h00;
            ptch      <= 16'h0000;
            ptch_rt   <= 16'h0000;
            vld       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            timer <= timer + 1'b1;
            vld   <= 1'b0;

            if (raise) begin
                cmd_req   <= 1'b1;
                cmd_wr    <= wr_nxt;
                cmd_addr  <= addr_nxt;
                cmd_wdata <= wdata_nxt;
            end else if (done || tmo) begin
                cmd_req <= 1'b0;
            end

            if (done) begin
                case (state)
                    INIT1: init_done <= 1'b1;
                    RD_PL: lo_p <= cmd_rdata;
                    RD_PH: hi_p <= cmd_rdata;
                    RD_RL: lo_r <= cmd_rdata;
                    RD_RH: begin
                        // Loaded on the transition into PUB so the new pair
                        // and vld are both presented during the PUB cycle,
                        // one cycle after the final ack.
                        ptch    <= {hi_p, lo_p};
                        ptch_rt <= {cmd_rdata, lo_r};
                        vld     <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inert_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_inert_rd_sched
// Purpose  : Self-checking bench for inert_rd_sched. A behavioural command
//            engine acks each request 3 cycles after it rises and checks the
//            command sequence against a queue of expected commands; a
//            publish monitor checks vld/ptch/ptch_rt against expected pairs
//            pushed by the engine when the final read is acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inert_rd_sched;

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] r;
    } pub_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cmd_req;
    logic        cmd_wr;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        cmd_ack;
    logic [7:0]  cmd_rdata;
    logic [15:0] ptch;
    logic [15:0] ptch_rt;
    logic        vld;
    logic        init_done;
    logic        err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   rise_22 = -1;
    int   last_ack_cyc = -10;
    int   vld_cnt = 0;
    int   spur_at_cyc = -1;
    int   hi_cnt = 0;
    int   tmo_len = 0;
    bit   tmo_seen = 1'b0;
    bit   spur_after_ack = 1'b0;
    bit   busy = 1'b0;
    bit   drop_chk = 1'b0;
    logic [6:0] cur_addr = 7'h00;
    logic [6:0] noack_addr = 7'h7F;
    cmd_t hold;
    cmd_t exp_cmd[$];
    pub_t exp_pub[$];
    logic [7:0] rd_tbl [0:127];

    inert_rd_sched #(.fast_sim(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmd_req   (cmd_req),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_ack   (cmd_ack),
        .cmd_rdata (cmd_rdata),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .vld       (vld),
        .init_done (init_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- command engine model / command scoreboard ----------
    initial begin
        cmd_t e;
        pub_t pe;
        cmd_ack   = 1'b0;
        cmd_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                busy     = 1'b0;
                drop_chk = 1'b0;
                cmd_ack  = 1'b0;
            end else begin
                if (cmd_ack) begin
                    cmd_ack = 1'b0;
                    if (drop_chk) begin
                        drop_chk = 1'b0;
                        checks++;
                        if (cmd_req !== 1'b0) begin
                            errors++;
                            $display("FAIL req_drop: cmd_req=%b required 0", cmd_req);
                        end
                    end
                    if (spur_after_ack) begin
                        spur_after_ack = 1'b0;
                        cmd_ack   = 1'b1;
                        cmd_rdata = 8'hEE;
                    end
                end else if (cyc == spur_at_cyc && !busy && cmd_req === 1'b0) begin
                    cmd_ack   = 1'b1;
                    cmd_rdata = 8'hEE;
                end
                if (busy) begin
                    if (cmd_req !== 1'b1) begin
                        busy     = 1'b0;
                        tmo_len  = hi_cnt;
                        tmo_seen = 1'b1;
                    end else begin
                        hi_cnt++;
                        checks++;
                        if ({cmd_wr, cmd_addr, cmd_wdata} !== hold) begin
                            errors++;
                            $display("FAIL cmd_stable: got %h required %h",
                                     {cmd_wr, cmd_addr, cmd_wdata}, hold);
                        end
                        if (hold.addr != noack_addr && hi_cnt == 3) begin
                            cmd_ack      = 1'b1;
                            cmd_rdata    = rd_tbl[hold.addr];
                            busy         = 1'b0;
                            drop_chk     = 1'b1;
                            last_ack_cyc = cyc;
                            if (hold.addr == 7'h25) begin
                                pe.p = {rd_tbl[7'h23], rd_tbl[7'h22]};
                                pe.r = {rd_tbl[7'h25], rd_tbl[7'h24]};
                                exp_pub.push_back(pe);
                            end
                        end
                    end
                end else if (cmd_req === 1'b1) begin
                    hold     = {cmd_wr, cmd_addr, cmd_wdata};
                    busy     = 1'b1;
                    hi_cnt   = 1;
                    cur_addr = cmd_addr;
                    if (cmd_addr == 7'h22) rise_22 = cyc;
                    checks++;
                    if (exp_cmd.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_req: got %h required none", hold);
                    end else begin
                        e = exp_cmd.pop_front();
                        if ({hold.wr, hold.addr} !== {e.wr, e.addr} ||
                            (e.wr && hold.wdata !== e.wdata)) begin
                            errors++;
                            $display("FAIL cmd_seq: got %h required %h", hold, e);
                        end
                    end
                end
            end
        end
    end

    // ---------------- publish monitor ------------------------------------
    initial begin
        pub_t        pe;
        logic        prev_vld = 1'b0;
        logic [15:0] prev_p = 16'h0;
        logic [15:0] prev_r = 16'h0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                prev_vld = 1'b0;
                prev_p   = ptch;
                prev_r   = ptch_rt;
            end else begin
                if (vld === 1'b1) begin
                    vld_cnt++;
                    checks++;
                    if (exp_pub.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_vld: ptch=%h ptch_rt=%h required no vld", ptch, ptch_rt);
                    end else begin
                        pe = exp_pub.pop_front();
                        if ({ptch, ptch_rt} !== {pe.p, pe.r}) begin
                            errors++;
                            $display("FAIL pub_data: got %h/%h required %h/%h", ptch, ptch_rt, pe.p, pe.r);
                        end
                    end
                    checks++;
                    if (cyc != last_ack_cyc + 1) begin
                        errors++;
                        $display("FAIL vld_latency: got %0d required %0d cycles", cyc - last_ack_cyc, 1);
                    end
                    checks++;
                    if (prev_vld !== 1'b0) begin
                        errors++;
                        $display("FAIL vld_width: vld high for 2+ cycles, required 1");
                    end
                end else if (ptch !== prev_p || ptch_rt !== prev_r) begin
                    checks++;
                    errors++;
                    $display("FAIL ptch_hold: changed to %h/%h without vld, required %h/%h",
                             ptch, ptch_rt, prev_p, prev_r);
                end
                prev_vld = vld;
                prev_p   = ptch;
                prev_r   = ptch_rt;
            end
        end
    end

    // ---------------- stimulus helpers -----------------------------------
    task automatic push_init();
        exp_cmd.push_back({1'b1, 7'h10, 8'h62});
        exp_cmd.push_back({1'b1, 7'h11, 8'h4C});
    endtask

    task automatic push_set(input logic [7:0] pl, input logic [7:0] ph,
                            input logic [7:0] rl, input logic [7:0] rh);
        rd_tbl[7'h22] = pl;
        rd_tbl[7'h23] = ph;
        rd_tbl[7'h24] = rl;
        rd_tbl[7'h25] = rh;
        exp_cmd.push_back({1'b0, 7'h22, 8'h00});
        exp_cmd.push_back({1'b0, 7'h23, 8'h00});
        exp_cmd.push_back({1'b0, 7'h24, 8'h00});
        exp_cmd.push_back({1'b0, 7'h25, 8'h00});
    endtask

    task automatic wait_vld(input int n0, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (vld_cnt > n0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_busy_on(input logic [6:0] a, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (busy && cur_addr == a && cmd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_init(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ------------------------------------------
    task automatic test_reset();
        bit ok;
        @(negedge clk);
        checks++;
        if ({cmd_req, cmd_wr, vld, init_done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: req/wr/vld/init/err=%b required 00000",
                     {cmd_req, cmd_wr, vld, init_done, err});
        end
        checks++;
        if (cmd_addr !== 7'h00 || cmd_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_cmd: addr=%h wdata=%h required 00/00", cmd_addr, cmd_wdata);
        end
        checks++;
        if (ptch !== 16'h0 || ptch_rt !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: ptch=%h ptch_rt=%h required 0/0", ptch, ptch_rt);
        end
        push_init();
        #2 rst = 1'b0;
        rel_cyc = cyc + 1;
        wait_init(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL init_done: init_done=%b required 1 within 40 cycles", init_done);
        end
        checks++;
        if (cyc != last_ack_cyc + 1) begin
            errors++;
            $display("FAIL init_done_time: %0d cycles after 2nd ack, required 1", cyc - last_ack_cyc);
        end
        checks++;
        if (exp_cmd.size() != 0) begin
            errors++;
            $display("FAIL init_writes: %0d writes missing, required 0", exp_cmd.size());
        end
    endtask

    task automatic test_sample();
        bit ok;
        int r1;
        en = 1'b1;
        push_set(8'h34, 8'h12, 8'hCD, 8'hAB);
        wait_vld(vld_cnt, 700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sample1_vld: no vld, required one within 700 cycles");
        end
        checks++;
        if (rise_22 != rel_cyc + 512) begin
            errors++;
            $display("FAIL first_tick: first read at %0d cycles after reset, required 512", rise_22 - rel_cyc);
        end
        r1 = rise_22;
        push_set(8'h5A, 8'hC3, 8'h01, 8'h80);
        wait_vld(vld_cnt, 700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sample2_vld: no vld, required one within 700 cycles");
        end
        checks++;
        if (rise_22 - r1 != 512) begin
            errors++;
            $display("FAIL period: got %0d required 512", rise_22 - r1);
        end
    endtask

    task automatic test_en_drop();
        bit ok;
        int n1;
        int r1;
        int en_cyc;
        push_set(8'h11, 8'h22, 8'h33, 8'h44);
        wait_busy_on(7'h23, 700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL en_drop_reach: RD_PH request not seen, required within 700 cycles");
        end
        en = 1'b0;
        r1 = rise_22;
        wait_vld(vld_cnt, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL en_drop_vld: in-flight set not published, required one vld");
        end
        n1 = vld_cnt;
        repeat (1100) @(negedge clk);
        checks++;
        if (vld_cnt != n1 || busy) begin
            errors++;
            $display("FAIL en_low_idle: vld_cnt=%0d busy=%0d required %0d/0", vld_cnt, busy, n1);
        end
        en = 1'b1;
        en_cyc = cyc;
        push_set(8'h9F, 8'h00, 8'hFF, 8'h7E);
        wait_vld(vld_cnt, 700, ok);
        checks++;
        if (!ok || (rise_22 - r1) % 512 != 0 || rise_22 - en_cyc > 513) begin
            errors++;
            $display("FAIL en_resume: ok=%0d rise offset %0d after en, required first tick", ok, rise_22 - en_cyc);
        end
    endtask

    task automatic test_spurious();
        bit ok;
        int r1;
        r1 = rise_22;
        spur_at_cyc    = r1 + 510;
        spur_after_ack = 1'b1;
        push_set(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        wait_vld(vld_cnt, 700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL spur_vld: no vld, required one within 700 cycles");
        end
        checks++;
        if (rise_22 - r1 != 512) begin
            errors++;
            $display("FAIL spur_tick: set began %0d after previous, required 512", rise_22 - r1);
        end
        spur_at_cyc = -1;
    endtask

    task automatic test_rst_mid();
        bit ok;
        push_set(8'h01, 8'h02, 8'h03, 8'h04);
        wait_busy_on(7'h24, 700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_reach: RD_RL request not seen, required within 700 cycles");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_req, init_done, vld} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async_ctl: req/init/vld=%b required 000", {cmd_req, init_done, vld});
        end
        checks++;
        if (ptch !== 16'h0 || ptch_rt !== 16'h0) begin
            errors++;
            $display("FAIL rst_async_data: ptch=%h ptch_rt=%h required 0/0", ptch, ptch_rt);
        end
        @(negedge clk);
        exp_cmd.delete();
        exp_pub.delete();
        repeat (2) @(negedge clk);
        en = 1'b0;
        push_init();
        #2 rst = 1'b0;
        wait_init(40, ok);
        checks++;
        if (!ok || exp_cmd.size() != 0) begin
            errors++;
            $display("FAIL rst_reinit: init_done=%b writes left=%0d required 1/0", init_done, exp_cmd.size());
        end
    endtask

`ifdef INERT_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int r1;
        en         = 1'b1;
        noack_addr = 7'h23;
        tmo_seen   = 1'b0;
        rd_tbl[7'h22] = 8'h66;
        exp_cmd.push_back({1'b0, 7'h22, 8'h00});
        exp_cmd.push_back({1'b0, 7'h23, 8'h00});
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (tmo_seen) break;
        end
        checks++;
        if (!tmo_seen || tmo_len != 255) begin
            errors++;
            $display("FAIL tmo_len: seen=%0d len=%0d required 1/255", tmo_seen, tmo_len);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_err: err=%b required 1", err);
        end
        r1 = rise_22;
        noack_addr = 7'h7F;
        push_set(8'h21, 8'h43, 8'h65, 8'h87);
        wait_vld(vld_cnt, 800, ok);
        checks++;
        if (!ok || rise_22 - r1 != 512) begin
            errors++;
            $display("FAIL tmo_retry: ok=%0d retry after %0d cycles, required 512", ok, rise_22 - r1);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b required 1", err);
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) rd_tbl[i] = 8'h00;
        rst = 1'b0;
        en  = 1'b0;
        #1 rst = 1'b1;
        test_reset();
        test_sample();
        test_en_drop();
        test_spurious();
        test_rst_mid();
`ifdef INERT_TIMEOUT_EN
        test_timeout();
`endif
        repeat (20) @(negedge clk);
        checks++;
        if (exp_cmd.size() != 0 || exp_pub.size() != 0) begin
            errors++;
            $display("FAIL leftover: cmds=%0d pubs=%0d outstanding, required 0/0", exp_cmd.size(), exp_pub.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
